cp0_exc_ctrl: RTL and testbench

Coprocessor-0 exception/interrupt controller for the single-issue MIPS core. It owns Status, Cause and EPC, serves mfc0/mtc0, and arbitrates synchronous exceptions against the external interrupt line. It sequences exception entry and `eret` return by driving flush, stall and PC-redirect into the fetch/datapath. It sits beside the register file, and its redirect output feeds the PC mux ahead of instruction memory.

---
 rtl/cp0_exc_ctrl_pkg.sv | 41 ++++
 rtl/cp0_exc_ctrl_if.sv | 40 ++++
 rtl/cp0_exc_prio.sv | 49 ++++
 rtl/cp0_exc_ctrl.sv | 151 +++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/cp0_exc_ctrl_pkg.sv
// ============================================================================
// Module      : cp0_pkg
// Description : Shared constants for the CP0 exception/interrupt controller:
//               CP0 register numbers, ExcCodes, Status/Cause bit positions
//               and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0] c_reg_count  = 5'd9;
    localparam logic [4:0] c_reg_status = 5'd12;
    localparam logic [4:0] c_reg_cause  = 5'd13;
    localparam logic [4:0] c_reg_epc    = 5'd14;

    // Exception codes written into Cause[6:2]
    localparam logic [4:0] c_exc_int = 5'd0;
    localparam logic [4:0] c_exc_sys = 5'd8;
    localparam logic [4:0] c_exc_ri  = 5'd10;
    localparam logic [4:0] c_exc_ov  = 5'd12;

    // Bit positions
    localparam int c_status_im2   = 10;
    localparam int c_status_exl   = 1;
    localparam int c_cause_ip2    = 10;
    localparam int c_cause_exc_lo = 2;
    localparam int c_cause_exc_hi = 6;

    // Controller sequencing states
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ENTRY = 2'd1,
        ST_VEC   = 2'd2,
        ST_RET   = 2'd3
    } cp0_state_e;

endpackage

`default_nettype wire

// File: rtl/cp0_exc_ctrl_if.sv
// ============================================================================
// Module      : cp0_exc_ctrl_if
// Description : Core <-> CP0 signal bundle. The master modport is the
//               pipeline side (commit info, mtc0/mfc0, interrupt line); the
//               slave modport is the CP0 controller (flush/stall/redirect).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cp0_exc_ctrl_if;
    logic        Int;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic        ov_exc;
    logic        sys_exc;
    logic        ri_exc;
    logic        eret;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output Int, inst_valid, inst_pc, ov_exc, sys_exc, ri_exc, eret,
               cp0_we, cp0_addr, cp0_wdata,
        input  cp0_rdata, flush, stall, redirect, redirect_pc
    );

    modport slave (
        input  Int, inst_valid, inst_pc, ov_exc, sys_exc, ri_exc, eret,
               cp0_we, cp0_addr, cp0_wdata,
        output cp0_rdata, flush, stall, redirect, redirect_pc
    );
endinterface

`default_nettype wire

// File: rtl/cp0_exc_prio.sv
// ============================================================================
// Module      : cp0_exc_prio
// Description : Combinational exception priority encoder.
//               RI > Sys > Ov > interrupt. i_int_ok is the already-qualified
//               interrupt condition (pending, enabled, not in handler, no
//               eret/mtc0 this cycle).
//   Ports     : i_inst_valid, i_ri_exc, i_sys_exc, i_ov_exc, i_int_ok
//               o_accept, o_exccode[4:0], o_is_int
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_exc_prio
    import cp0_pkg::*;
(
    input  logic       i_inst_valid,
    input  logic       i_ri_exc,
    input  logic       i_sys_exc,
    input  logic       i_ov_exc,
    input  logic       i_int_ok,
    output logic       o_accept,
    output logic [4:0] o_exccode,
    output logic       o_is_int
);

    always_comb begin
        o_accept  = 1'b0;
        o_exccode = c_exc_int;
        o_is_int  = 1'b0;
        if (i_inst_valid) begin
            if (i_ri_exc) begin
                o_accept  = 1'b1;
                o_exccode = c_exc_ri;
            end else if (i_sys_exc) begin
                o_accept  = 1'b1;
                o_exccode = c_exc_sys;
            end else if (i_ov_exc) begin
                o_accept  = 1'b1;
                o_exccode = c_exc_ov;
            end else if (i_int_ok) begin
                o_accept  = 1'b1;
                o_is_int  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
// ============================================================================
// Module      : cp0_exc_ctrl
// Description : Coprocessor-0 exception/interrupt controller. Holds Status,
//               Cause and EPC, serves mfc0/mtc0, arbitrates exceptions
//               against the interrupt line and sequences entry (ENTRY->VEC)
//               and eret return (RET) via flush/stall/redirect.
//   Ports     : Clk, Reset (sync, active-high), bus (cp0_exc_ctrl_if.slave)
//   Config    : CP0_EXC_COUNT_EN - adds a 32-bit exception-entry Count at
//               CP0 reg 9 (mtc0 writable). Undefined: reg 9 reads 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0054
) (
    input  logic          Clk,
    input  logic          Reset,
    cp0_exc_ctrl_if.slave bus
);

    cp0_state_e  r_state, w_next;
    logic [31:0] r_status;
    logic [4:0]  r_exccode;
    logic        r_ip2;
    logic [31:0] r_epc;

    logic        w_run, w_int_ok, w_prio_accept, w_is_int;
    logic        w_accept, w_sync, w_eret, w_we;
    logic [4:0]  w_exccode;

    // Every input except Int is only honoured in RUN.
    assign w_run    = (r_state == ST_RUN);
    assign w_int_ok = r_ip2 & r_status[c_status_im2] & ~r_status[c_status_exl]
                      & ~bus.eret & ~bus.cp0_we;

    cp0_exc_prio u_prio (
        .i_inst_valid (bus.inst_valid),
        .i_ri_exc     (bus.ri_exc),
        .i_sys_exc    (bus.sys_exc),
        .i_ov_exc     (bus.ov_exc),
        .i_int_ok     (w_int_ok),
        .o_accept     (w_prio_accept),
        .o_exccode    (w_exccode),
        .o_is_int     (w_is_int)
    );

    assign w_accept = w_run & w_prio_accept;
    assign w_sync   = w_accept & ~w_is_int;
    assign w_eret   = w_run & ~w_accept & bus.eret;
    // A synchronous exception squashes the mtc0 of the same instruction.
    assign w_we     = w_run & bus.cp0_we & ~w_sync;

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= ST_RUN;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        bus.flush       = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        case (r_state)
            ST_RUN: begin
                if (w_accept)    w_next = ST_ENTRY;
                else if (w_eret) w_next = ST_RET;
            end
            ST_ENTRY: begin
                bus.flush = 1'b1;
                bus.stall = 1'b1;
                w_next    = ST_VEC;
            end
            ST_VEC: begin
                bus.redirect    = 1'b1;
                bus.redirect_pc = EXC_VECTOR;
                w_next          = ST_RUN;
            end
            ST_RET: begin
                bus.redirect    = 1'b1;
                bus.redirect_pc = r_epc;
                bus.flush       = 1'b1;
                w_next          = ST_RUN;
            end
            default: w_next = ST_RUN;
        endcase
    end

    // Later assignments take precedence: exception/eret updates override a
    // coincident mtc0 on the same bits.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_status  <= 32'h0;
            r_exccode <= 5'h0;
            r_ip2     <= 1'b0;
            r_epc     <= 32'h0;
        end else begin
            r_ip2 <= bus.Int;
            if (w_we) begin
                case (bus.cp0_addr)
                    c_reg_status: r_status  <= bus.cp0_wdata;
                    c_reg_cause:  r_exccode <= bus.cp0_wdata[c_cause_exc_hi:c_cause_exc_lo];
                    c_reg_epc:    r_epc     <= bus.cp0_wdata;
                    default: ;
                endcase
            end
            if (w_accept) begin
                // An interrupt lets the instruction complete, so resume after it.
                r_epc                  <= w_is_int ? (bus.inst_pc + 32'd4) : bus.inst_pc;
                r_exccode              <= w_exccode;
                r_status[c_status_exl] <= 1'b1;
            end
            if (w_eret) r_status[c_status_exl] <= 1'b0;
        end
    end

`ifdef CP0_EXC_COUNT_EN
    logic [31:0] r_count;

    always_ff @(posedge Clk) begin
        if (Reset)
            r_count <= 32'h0;
        else if (w_accept)
            r_count <= r_count + 32'd1;
        else if (w_we && (bus.cp0_addr == c_reg_count))
            r_count <= bus.cp0_wdata;
    end
`endif

    always_comb begin
        bus.cp0_rdata = 32'h0;
        case (bus.cp0_addr)
            c_reg_status: bus.cp0_rdata = r_status;
            c_reg_cause: begin
                bus.cp0_rdata[c_cause_ip2]                   = r_ip2;
                bus.cp0_rdata[c_cause_exc_hi:c_cause_exc_lo] = r_exccode;
            end
            c_reg_epc:    bus.cp0_rdata = r_epc;
`ifdef CP0_EXC_COUNT_EN
            c_reg_count:  bus.cp0_rdata = r_count;
`endif
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
// ============================================================================
// Module      : tb_cp0_exc_ctrl
// Description : Self-checking bench for cp0_exc_ctrl. Redirects are checked
//               by a scoreboard monitor against expectations queued when the
//               triggering stimulus is issued; mfc0 reads are checked inline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cp0_exc_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic        flush;
        logic        prev_stall;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     checks = 0;
    int     errors = 0;
    int     n_entries = 0;
    exp_t   q[$];
    logic   r_prev_stall = 1'b0;

    cp0_exc_ctrl_if bus ();

    cp0_exc_ctrl #(.EXC_VECTOR(32'h0000_0054)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string name);
        bus.cp0_addr = addr;
        #1;
        chk(name, bus.cp0_rdata, exp);
    endtask

    task automatic expect_vec();
        exp_t e;
        e.pc = 32'h54; e.flush = 1'b0; e.prev_stall = 1'b1;
        q.push_back(e);
        n_entries++;
    endtask

    task automatic expect_ret(input logic [31:0] epc);
        exp_t e;
        e.pc = epc; e.flush = 1'b1; e.prev_stall = 1'b0;
        q.push_back(e);
    endtask

    task automatic clr();
        bus.inst_valid = 0; bus.ov_exc = 0; bus.sys_exc = 0; bus.ri_exc = 0;
        bus.eret = 0; bus.cp0_we = 0;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        bus.cp0_we = 1; bus.cp0_addr = addr; bus.cp0_wdata = data;
        step();
        bus.cp0_we = 0;
    endtask

    task automatic do_eret(input logic [31:0] epc);
        bus.eret = 1; bus.inst_valid = 1;
        expect_ret(epc);
        step();
        clr();
        step();
    endtask

    // Scoreboard monitor: every redirect must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.redirect) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL redirect_unexpected: got pc %h expected none", bus.redirect_pc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (bus.redirect_pc !== e.pc || bus.flush !== e.flush ||
                    r_prev_stall !== e.prev_stall) begin
                    errors++;
                    $display("FAIL redirect: got pc %h flush %b prev_stall %b expected pc %h flush %b prev_stall %b",
                             bus.redirect_pc, bus.flush, r_prev_stall, e.pc, e.flush, e.prev_stall);
                end
            end
        end
        r_prev_stall = bus.stall;
    end

    initial begin
        bus.Int = 0; bus.inst_pc = 0; bus.cp0_addr = 0; bus.cp0_wdata = 0;
        clr();
        step(); step();
        rst = 0;

        // Reset state
        rd(5'd12, 32'h0, "rst_status");
        rd(5'd13, 32'h0, "rst_cause");
        rd(5'd14, 32'h0, "rst_epc");
        chk("rst_flush", {31'h0, bus.flush}, 32'h0);
        chk("rst_stall", {31'h0, bus.stall}, 32'h0);
        chk("rst_redirect", {31'h0, bus.redirect}, 32'h0);

        // Interrupt: EPC = pc + 4, ExcCode 0
        bus.Int = 1;
        mtc0(5'd12, 32'h400);
        bus.inst_valid = 1; bus.inst_pc = 32'h5C;
        expect_vec();
        step();
        clr(); bus.Int = 0;
        chk("entry_stall", {31'h0, bus.stall}, 32'h1);
        chk("entry_flush", {31'h0, bus.flush}, 32'h1);
        step(); step();
        rd(5'd14, 32'h60, "int_epc");
        rd(5'd13, 32'h0, "int_cause");
        rd(5'd12, 32'h402, "int_status");
        do_eret(32'h60);
        rd(5'd12, 32'h400, "int_eret_status");

        // Ov + Sys together: Sys wins
        bus.inst_valid = 1; bus.ov_exc = 1; bus.sys_exc = 1; bus.inst_pc = 32'h20;
        expect_vec();
        step(); clr(); step(); step();
        rd(5'd13, 32'h20, "sys_cause");
        rd(5'd14, 32'h20, "sys_epc");
        rd(5'd12, 32'h402, "sys_status");
        do_eret(32'h20);

        // Ov with coincident mtc0: write dropped
        mtc0(5'd12, 32'h0);
        bus.inst_valid = 1; bus.ov_exc = 1; bus.inst_pc = 32'h30;
        bus.cp0_we = 1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h400;
        expect_vec();
        step(); clr(); step(); step();
        rd(5'd12, 32'h2, "ov_drop_status");
        rd(5'd13, 32'h30, "ov_cause");
        rd(5'd14, 32'h30, "ov_epc");
        do_eret(32'h30);
        rd(5'd12, 32'h0, "ov_eret_status");

        // Interrupt held while EXL=1, taken after eret
        mtc0(5'd12, 32'h400);
        bus.inst_valid = 1; bus.sys_exc = 1; bus.inst_pc = 32'h40;
        expect_vec();
        step(); clr(); step(); step();
        bus.Int = 1;
        step();
        bus.inst_valid = 1; bus.inst_pc = 32'h44;
        step(); clr(); step();
        rd(5'd13, 32'h420, "pend_cause");
        rd(5'd14, 32'h40, "pend_epc");
        do_eret(32'h40);
        rd(5'd12, 32'h400, "pend_eret_status");
        bus.inst_valid = 1; bus.inst_pc = 32'h100;
        expect_vec();
        step(); clr(); bus.Int = 0; step(); step();
        rd(5'd14, 32'h104, "pend_epc2");
        rd(5'd13, 32'h0, "pend_cause2");
        rd(5'd12, 32'h402, "pend_status2");

        // Count register and unimplemented register
`ifdef CP0_EXC_COUNT_EN
        rd(5'd9, n_entries, "count");
        mtc0(5'd9, 32'h10);
        rd(5'd9, 32'h10, "count_wr");
`else
        rd(5'd9, 32'h0, "count_absent");
        mtc0(5'd9, 32'h10);
        rd(5'd9, 32'h0, "count_absent_wr");
`endif
        mtc0(5'd5, 32'hDEAD);
        rd(5'd5, 32'h0, "reg5");

        // Reset during ENTRY aborts the sequence
        bus.inst_valid = 1; bus.ri_exc = 1; bus.inst_pc = 32'h200;
        step(); clr();
        chk("abort_stall", {31'h0, bus.stall}, 32'h1);
        rst = 1;
        step();
        rst = 0;
        chk("abort_flush", {31'h0, bus.flush}, 32'h0);
        chk("abort_stall2", {31'h0, bus.stall}, 32'h0);
        chk("abort_redirect", {31'h0, bus.redirect}, 32'h0);
        rd(5'd14, 32'h0, "abort_epc");
        step(); step(); step();
        chk("redirects_pending", q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
